// File: rtl/alu_pkg.sv
// Shared opcode, state and sizing definitions for the ALU sequencer slice.
package alu_pkg;

   localparam int DATA_W  = 8;
   localparam int REG_NUM = 8;
   localparam int ADDR_W  = 3;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_NOT = 4'b0100;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_NOR = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b0111;
   localparam logic [3:0] OP_SRL = 4'b1000;
   localparam logic [3:0] OP_SRA = 4'b1001;
   localparam logic [3:0] OP_ROL = 4'b1010;
   localparam logic [3:0] OP_ROR = 4'b1011;
   localparam logic [3:0] OP_EQ  = 4'b1100;

   localparam logic [3:0] OP_LAST_LEGAL = OP_EQ;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } seq_state_e;

   function automatic logic op_is_legal(input logic [3:0] op);
      return op <= OP_LAST_LEGAL;
   endfunction

   // Only add/subtract produce a meaningful carry; everything else reports 0.
   function automatic logic op_has_carry(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU driven by the sequencer. Shift/rotate amount is y[2:0].
// Carry is the add carry-out or the subtract borrow; for all other opcodes it
// reflects x's MSB, which the sequencer discards.
module alu
   import alu_pkg::*;
(
   input  logic [3:0]        ctrl,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   output logic              carry,
   output logic [DATA_W-1:0] out
);

   logic [DATA_W:0] sum;
   logic [2:0]      sh;
   logic [3:0]      sh_inv;

   assign sh     = y[2:0];
   assign sh_inv = 4'd8 - {1'b0, sh};

   // Opcode decode into result and carry.
   always_comb begin
      sum   = '0;
      out   = '0;
      carry = x[DATA_W-1];
      case (ctrl)
         OP_ADD: begin
            sum   = {1'b0, x} + {1'b0, y};
            out   = sum[DATA_W-1:0];
            carry = sum[DATA_W];
         end
         OP_SUB: begin
            sum   = {1'b0, x} - {1'b0, y};
            out   = sum[DATA_W-1:0];
            carry = sum[DATA_W];
         end
         OP_AND: out = x & y;
         OP_OR:  out = x | y;
         OP_NOT: out = ~x;
         OP_XOR: out = x ^ y;
         OP_NOR: out = ~(x | y);
         OP_SLL: out = x << sh;
         OP_SRL: out = x >> sh;
         OP_SRA: out = $signed(x) >>> sh;
         OP_ROL: out = (x << sh) | (x >> sh_inv);
         OP_ROR: out = (x >> sh) | (x << sh_inv);
         OP_EQ:  out = (x == y) ? 8'h01 : 8'h00;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/seq_regfile.sv
// Register file: two async read ports, one sync write port, r0 reads as zero.
module seq_regfile
   import alu_pkg::*;
#(
   parameter int DATA_W  = alu_pkg::DATA_W,
   parameter int REG_NUM = alu_pkg::REG_NUM,
   parameter int ADDR_W  = alu_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs_q [REG_NUM];
   logic [DATA_W-1:0] regs_d [REG_NUM];

   // Next register contents; r0 is forced back to zero whatever the write.
   always_comb begin
      regs_d = regs_q;
      if (wr_en && (wr_addr != '0)) begin
         regs_d[wr_addr] = wr_data;
      end
      regs_d[0] = '0;
   end

   // Register storage with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_data_a = regs_q[rd_addr_a];
   assign rd_data_b = regs_q[rd_addr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Instruction front end for the combinational ALU: operand fetch, one-cycle
// execute with writeback, then a held result presented downstream.
//
// state | meaning
// IDLE  | accepting external loads (priority) or a new instruction
// EXEC  | ALU settling on registered operands; result captured and written back
// RESP  | result offered downstream, held until res_ready
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W  = alu_pkg::DATA_W,
   parameter int REG_NUM = alu_pkg::REG_NUM,
   parameter int ADDR_W  = alu_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_ctrl,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [3:0]        alu_ctrl,
   output logic [DATA_W-1:0] alu_x,
   output logic [DATA_W-1:0] alu_y,
   input  logic              alu_carry,
   input  logic [DATA_W-1:0] alu_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_carry,
   output logic              res_illegal,
   output logic              busy
);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [3:0]        alu_ctrl_q, alu_ctrl_d;
   logic [DATA_W-1:0] alu_x_q, alu_x_d;
   logic [DATA_W-1:0] alu_y_q, alu_y_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              res_carry_q, res_carry_d;
   logic              res_illegal_q, res_illegal_d;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;

   // Operands are read straight from the array, so a same-cycle write is not seen.
   seq_regfile #(
      .DATA_W  (DATA_W),
      .REG_NUM (REG_NUM),
      .ADDR_W  (ADDR_W)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (in_rs1),
      .rd_data_a (rs1_data),
      .rd_addr_b (in_rs2),
      .rd_data_b (rs2_data),
      .wr_en     (rf_we),
      .wr_addr   (rf_waddr),
      .wr_data   (rf_wdata)
   );

   // Next-state, operand latch, result capture and register-write selection.
   always_comb begin
      state_d       = state_q;
      rd_d          = rd_q;
      alu_ctrl_d    = alu_ctrl_q;
      alu_x_d       = alu_x_q;
      alu_y_d       = alu_y_q;
      res_data_d    = res_data_q;
      res_carry_d   = res_carry_q;
      res_illegal_d = res_illegal_q;
      rf_we         = 1'b0;
      rf_waddr      = wr_addr;
      rf_wdata      = wr_data;
      case (state_q)
         IDLE: begin
            if (wr_en) begin
               rf_we = 1'b1;
            end else if (in_valid) begin
               alu_ctrl_d = in_ctrl;
               alu_x_d    = rs1_data;
               alu_y_d    = rs2_data;
               rd_d       = in_rd;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            res_data_d    = alu_out;
            res_carry_d   = op_has_carry(alu_ctrl_q) & alu_carry;
            res_illegal_d = !op_is_legal(alu_ctrl_q);
            if (op_is_legal(alu_ctrl_q) && (rd_q != '0)) begin
               rf_we    = 1'b1;
               rf_waddr = rd_q;
               rf_wdata = alu_out;
            end
            state_d = RESP;
         end
         RESP: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rd_q          <= '0;
         alu_ctrl_q    <= '0;
         alu_x_q       <= '0;
         alu_y_q       <= '0;
         res_data_q    <= '0;
         res_carry_q   <= 1'b0;
         res_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rd_q          <= rd_d;
         alu_ctrl_q    <= alu_ctrl_d;
         alu_x_q       <= alu_x_d;
         alu_y_q       <= alu_y_d;
         res_data_q    <= res_data_d;
         res_carry_q   <= res_carry_d;
         res_illegal_q <= res_illegal_d;
      end
   end

   assign in_ready    = (state_q == IDLE) && !wr_en && !rst;
   assign busy        = (state_q != IDLE);
   assign res_valid   = (state_q == RESP);
   assign alu_ctrl    = alu_ctrl_q;
   assign alu_x       = alu_x_q;
   assign alu_y       = alu_y_q;
   assign res_data    = res_data_q;
   assign res_carry   = res_carry_q;
   assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for the sequencer plus real ALU, with a result scoreboard.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_ctrl;
   logic [2:0] in_rd, in_rs1, in_rs2;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] alu_ctrl;
   logic [7:0] alu_x, alu_y;
   logic       alu_carry;
   logic [7:0] alu_out;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_carry;
   logic       res_illegal;
   logic       busy;

   typedef struct packed {
      logic [7:0] data;
      logic       carry;
      logic       illegal;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mregs [8];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ctrl     (in_ctrl),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .alu_ctrl    (alu_ctrl),
      .alu_x       (alu_x),
      .alu_y       (alu_y),
      .alu_carry   (alu_carry),
      .alu_out     (alu_out),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_carry   (res_carry),
      .res_illegal (res_illegal),
      .busy        (busy)
   );

   alu u_alu (
      .ctrl  (alu_ctrl),
      .x     (alu_x),
      .y     (alu_y),
      .carry (alu_carry),
      .out   (alu_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
      exp_t       e;
      logic [7:0] r;
      logic       c;
      int         s;
      s = int'(y[2:0]);
      c = 1'b0;
      r = 8'h00;
      case (op)
         4'd0:  begin r = x + y; c = (int'(x) + int'(y)) > 255; end
         4'd1:  begin r = x - y; c = (x < y); end
         4'd2:  r = x & y;
         4'd3:  r = x | y;
         4'd4:  r = ~x;
         4'd5:  r = x ^ y;
         4'd6:  r = ~(x | y);
         4'd7:  begin r = x; repeat (s) r = {r[6:0], 1'b0}; end
         4'd8:  begin r = x; repeat (s) r = {1'b0, r[7:1]}; end
         4'd9:  begin r = x; repeat (s) r = {r[7], r[7:1]}; end
         4'd10: begin r = x; repeat (s) r = {r[6:0], r[7]}; end
         4'd11: begin r = x; repeat (s) r = {r[0], r[7:1]}; end
         4'd12: r = (x == y) ? 8'h01 : 8'h00;
         default: r = 8'h00;
      endcase
      e.data    = r;
      e.carry   = c;
      e.illegal = (op >= 4'd13);
      return e;
   endfunction

   task automatic load(input logic [2:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
      wr_en = 1'b0;
      if (a != 3'd0) mregs[a] = d;
   endtask

   task automatic issue(input string tag, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input int hold);
      int   n;
      exp_t e;
      exp_t got;
      in_valid = 1'b1;
      in_ctrl  = op;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      #1;
      n = 0;
      while (in_ready !== 1'b1 && n < 8) begin step(); n++; end
      check({tag, ".in_ready"}, 32'(in_ready), 32'(1));
      step();
      in_valid = 1'b0;
      e = model(op, mregs[rs1], mregs[rs2]);
      sb.push_back(e);
      n = 0;
      while (res_valid !== 1'b1 && n < 8) begin step(); n++; end
      check({tag, ".latency"}, 32'(n), 32'(1));
      if (res_valid === 1'b1 && sb.size() > 0) begin
         got = sb.pop_front();
         check({tag, ".res_data"}, 32'(res_data), 32'(got.data));
         check({tag, ".res_carry"}, 32'(res_carry), 32'(got.carry));
         check({tag, ".res_illegal"}, 32'(res_illegal), 32'(got.illegal));
         for (int i = 0; i < hold; i++) begin
            wr_en   = 1'b1;
            wr_addr = rs2;
            wr_data = ~mregs[rs2];
            step();
            check({tag, ".hold_valid"}, 32'(res_valid), 32'(1));
            check({tag, ".hold_data"}, 32'(res_data), 32'(got.data));
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'(0));
         end
         wr_en = 1'b0;
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check({tag, ".idle_after"}, 32'(busy), 32'(0));
      if (op <= 4'd12 && rd != 3'd0) mregs[rd] = e.data;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_ctrl   = 4'd0;
      in_rd     = 3'd0;
      in_rs1    = 3'd0;
      in_rs2    = 3'd0;
      wr_en     = 1'b0;
      wr_addr   = 3'd0;
      wr_data   = 8'd0;
      res_ready = 1'b0;
      for (int i = 0; i < 8; i++) mregs[i] = 8'h00;

      step();
      step();
      check("rst.in_ready", 32'(in_ready), 32'(0));
      rst = 1'b0;
      #1;
      check("rst.in_ready_after", 32'(in_ready), 32'(1));
      check("rst.busy", 32'(busy), 32'(0));
      check("rst.res_valid", 32'(res_valid), 32'(0));
      check("rst.alu_bus", {12'd0, alu_ctrl, alu_x, alu_y}, 32'(0));
      check("rst.res", {22'd0, res_data, res_carry, res_illegal}, 32'(0));

      load(3'd1, 8'hFF);
      load(3'd2, 8'h01);
      issue("add", 4'd0, 3'd3, 3'd1, 3'd2, 0);
      issue("rd_r3", 4'd3, 3'd7, 3'd3, 3'd0, 0);

      load(3'd1, 8'h00);
      load(3'd2, 8'h01);
      issue("sub", 4'd1, 3'd4, 3'd1, 3'd2, 0);
      issue("and", 4'd2, 3'd5, 3'd4, 3'd4, 0);

      load(3'd6, 8'h5A);
      issue("illegal", 4'd14, 3'd6, 3'd4, 3'd1, 0);
      issue("rd_r6", 4'd3, 3'd7, 3'd6, 3'd0, 0);
      issue("xor_r0", 4'd5, 3'd0, 3'd4, 3'd2, 0);
      issue("rd_r0", 4'd3, 3'd7, 3'd0, 3'd0, 0);

      issue("hold", 4'd0, 3'd1, 3'd2, 3'd2, 5);
      issue("rd_r2", 4'd3, 3'd7, 3'd2, 3'd0, 0);

      wr_en    = 1'b1;
      wr_addr  = 3'd2;
      wr_data  = 8'h40;
      in_valid = 1'b1;
      in_ctrl  = 4'd0;
      in_rd    = 3'd3;
      in_rs1   = 3'd2;
      in_rs2   = 3'd2;
      #1;
      check("ld_prio.in_ready", 32'(in_ready), 32'(0));
      step();
      wr_en    = 1'b0;
      mregs[2] = 8'h40;
      check("ld_prio.not_accepted", 32'(busy), 32'(0));
      issue("ld_prio", 4'd0, 3'd3, 3'd2, 3'd2, 0);

      for (int op = 0; op < 16; op++) begin
         load(3'd1, 8'($urandom));
         load(3'd2, 8'($urandom_range(0, 255)));
         issue("sweep", 4'(op), 3'(op % 7 + 1), 3'd1, 3'd2, 0);
      end

      load(3'd3, 8'h77);
      in_valid = 1'b1;
      in_ctrl  = 4'd0;
      in_rd    = 3'd3;
      in_rs1   = 3'd3;
      in_rs2   = 3'd3;
      step();
      in_valid = 1'b0;
      sb.push_back(model(4'd0, mregs[3], mregs[3]));
      check("rst_exec.busy", 32'(busy), 32'(1));
      rst = 1'b1;
      step();
      sb.delete();
      for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
      check("rst_exec.busy_after", 32'(busy), 32'(0));
      check("rst_exec.res_valid", 32'(res_valid), 32'(0));
      check("rst_exec.alu_bus", {12'd0, alu_ctrl, alu_x, alu_y}, 32'(0));
      check("rst_exec.res", {22'd0, res_data, res_carry, res_illegal}, 32'(0));
      check("rst_exec.in_ready_rst", 32'(in_ready), 32'(0));
      rst = 1'b0;
      #1;
      check("rst_exec.in_ready", 32'(in_ready), 32'(1));
      issue("rd_r3_after_rst", 4'd3, 3'd7, 3'd3, 3'd0, 0);
      issue("rd_r1_after_rst", 4'd3, 3'd7, 3'd1, 3'd0, 0);

      check("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
